// File: rtl/mux_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_ctrl_if
// Purpose  : Bundles the scan request (start, d) and the scan result signals
//            (s, y, valid, busy, done) between a requester and mux_scan_ctrl.
// Ports    : none (signals only)
//   start  - request to scan a new 4-bit word
//   d      - parallel word to scan
//   s      - current select value for the downstream 4:1 mux
//   y      - selected bit of the captured word
//   valid  - y/s carry a scan bit
//   busy   - controller is in RUN or DONE
//   done   - single-cycle end-of-scan pulse
// Revision : 1.0 - initial release
// ============================================================================
interface mux_scan_ctrl_if;
  logic       start;
  logic [3:0] d;
  logic [1:0] s;
  logic       y;
  logic       valid;
  logic       busy;
  logic       done;

  // Requester side: issues scan requests, observes results.
  modport master (
    output start,
    output d,
    input  s,
    input  y,
    input  valid,
    input  busy,
    input  done
  );

  // Controller side.
  modport slave (
    input  start,
    input  d,
    output s,
    output y,
    output valid,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_ctrl
// Purpose  : Captures a 4-bit word on an accepted start and walks the mux
//            select s through 00,01,10,11, holding each value HOLD cycles and
//            presenting the selected bit on y. Ends with a one-cycle DONE.
// Ports    :
//   clk    - rising-edge clock
//   rst    - synchronous, active-high reset
//   bus    - mux_scan_ctrl_if.slave (start, d in; s, y, valid, busy, done out)
// Params   :
//   HOLD   - cycles each select value is held (1..255)
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int unsigned HOLD = 1
) (
  input  logic               clk,
  input  logic               rst,
  mux_scan_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last count value of the hold counter for one select value.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] d_reg_q, d_reg_d;
  logic [1:0] s_q,     s_d;
  logic [7:0] hold_q,  hold_d;
  logic       y_q,     y_d;
  logic       valid_q, valid_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;

  // All outputs are registered: the next-state logic computes the values the
  // outputs must show in the cycle after the edge, so the first valid bit
  // appears right after the edge that accepts start.
  always_comb begin
    state_d = state_q;
    d_reg_d = d_reg_q;
    s_d     = s_q;
    hold_d  = hold_q;
    y_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        s_d    = 2'b00;
        hold_d = 8'd0;
        if (bus.start) begin
          state_d = RUN;
          d_reg_d = bus.d;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          // Present the new word's bit 0 straight away.
          y_d     = bus.d[0];
        end
      end

      RUN: begin
        busy_d = 1'b1;
        if (hold_q == HOLD_LAST) begin
          hold_d = 8'd0;
          if (s_q == 2'b11) begin
            // Last select value fully held: finish without wrapping s.
            state_d = DONE;
            done_d  = 1'b1;
            s_d     = 2'b11;
          end else begin
            s_d     = s_q + 2'd1;
            valid_d = 1'b1;
            y_d     = d_reg_q[s_d];
          end
        end else begin
          hold_d  = hold_q + 8'd1;
          valid_d = 1'b1;
          y_d     = d_reg_q[s_q];
        end
      end

      DONE: begin
        // start is ignored here; the next IDLE cycle may accept a new one.
        state_d = IDLE;
        s_d     = 2'b00;
        hold_d  = 8'd0;
      end

      default: begin
        state_d = IDLE;
        s_d     = 2'b00;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d_reg_q <= 4'b0000;
      s_q     <= 2'b00;
      hold_q  <= 8'd0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_reg_q <= d_reg_d;
      s_q     <= s_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.s     = s_q;
  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_ctrl
// Purpose  : Self-checking bench for mux_scan_ctrl with HOLD = 1, 2 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

  logic clk;
  logic rst;

  logic       start1, start2, start3;
  logic [3:0] d1, d2, d3;

  int n_cmp;
  int n_bad;

  mux_scan_ctrl_if if1 ();
  mux_scan_ctrl_if if2 ();
  mux_scan_ctrl_if if3 ();

  assign if1.start = start1;
  assign if1.d     = d1;
  assign if2.start = start2;
  assign if2.d     = d2;
  assign if3.start = start3;
  assign if3.d     = d3;

  mux_scan_ctrl #(.HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mux_scan_ctrl #(.HOLD(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  mux_scan_ctrl #(.HOLD(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] d;
    logic [1:0] s;
    logic       y;
    logic       valid;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic st, input logic [3:0] dd,
                     input logic [1:0] es, input logic ey, input logic ev,
                     input logic eb, input logic ed);
    vec_t v;
    v.rst = r; v.start = st; v.d = dd;
    v.s = es; v.y = ey; v.valid = ev; v.busy = eb; v.done = ed;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] w;
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    d1     = 4'h0; d2     = 4'h0; d3     = 4'h0;

    // ---- HOLD=1 table: inputs applied before an edge, outputs after it ----
    //   rst st  d      s      y     v     b     dn
    add(1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // 0 reset
    add(1'b1, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // 1 rst beats start
    add(1'b0, 1'b0, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // 2 idle
    add(1'b0, 1'b1, 4'h5, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0); // 3 start d=0101
    add(1'b0, 1'b0, 4'h5, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0); // 4
    add(1'b0, 1'b0, 4'hA, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0); // 5 d changes
    add(1'b0, 1'b1, 4'hA, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0); // 6 start in RUN
    add(1'b0, 1'b1, 4'hA, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1); // 7 DONE
    add(1'b0, 1'b1, 4'hA, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // 8 start in DONE ignored
    add(1'b0, 1'b1, 4'h3, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0); // 9 start in IDLE, d=0011
    add(1'b0, 1'b0, 4'h3, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0); // 10
    add(1'b0, 1'b0, 4'h3, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0); // 11
    add(1'b0, 1'b0, 4'h3, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0); // 12
    add(1'b0, 1'b0, 4'h3, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1); // 13 single DONE
    add(1'b0, 1'b0, 4'h3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // 14 idle
    add(1'b0, 1'b0, 4'h3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // 15 no second done

    foreach (vecs[i]) begin
      rst    = vecs[i].rst;
      start1 = vecs[i].start;
      d1     = vecs[i].d;
      tick();
      chk($sformatf("v%0d s", i),     int'(if1.s),     int'(vecs[i].s));
      chk($sformatf("v%0d y", i),     int'(if1.y),     int'(vecs[i].y));
      chk($sformatf("v%0d valid", i), int'(if1.valid), int'(vecs[i].valid));
      chk($sformatf("v%0d busy", i),  int'(if1.busy),  int'(vecs[i].busy));
      chk($sformatf("v%0d done", i),  int'(if1.done),  int'(vecs[i].done));
      if (i == 1)
        chk("rst_start d_reg", int'(dut1.d_reg_q), 0);
    end
    start1 = 1'b0;

    // ---- HOLD=3, d=1100: 12 valid cycles, done on cycle 13 ----
    w      = 4'b1100;
    d3     = w;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk($sformatf("h3 c%0d s", i + 1),     int'(if3.s),     i / 3);
      chk($sformatf("h3 c%0d y", i + 1),     int'(if3.y),     int'(w[i / 3]));
      chk($sformatf("h3 c%0d valid", i + 1), int'(if3.valid), 1);
      chk($sformatf("h3 c%0d done", i + 1),  int'(if3.done),  0);
    end
    tick();
    chk("h3 c13 done",  int'(if3.done),  1);
    chk("h3 c13 valid", int'(if3.valid), 0);
    chk("h3 c13 s",     int'(if3.s),     3);
    chk("h3 c13 busy",  int'(if3.busy),  1);
    tick();
    chk("h3 c14 busy",  int'(if3.busy),  0);
    chk("h3 c14 done",  int'(if3.done),  0);
    chk("h3 c14 s",     int'(if3.s),     0);

    // ---- HOLD=2, reset while s=10 aborts the scan ----
    d2     = 4'b0100;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("h2 c1 s", int'(if2.s), 0);
    tick();
    chk("h2 c2 s", int'(if2.s), 0);
    tick();
    chk("h2 c3 s", int'(if2.s), 1);
    tick();
    tick();
    chk("h2 c5 s", int'(if2.s), 2);
    chk("h2 c5 y", int'(if2.y), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("h2 rst s",     int'(if2.s),     0);
    chk("h2 rst y",     int'(if2.y),     0);
    chk("h2 rst valid", int'(if2.valid), 0);
    chk("h2 rst busy",  int'(if2.busy),  0);
    chk("h2 rst done",  int'(if2.done),  0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("h2 post%0d done", i),  int'(if2.done),  0);
      chk($sformatf("h2 post%0d valid", i), int'(if2.valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
